// File: rtl/cluster_header_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cluster_header_seq                                            |
// | Brief    : Cluster reset header. Synchronises per-channel reset requests |
// |            and a clock enable into gclk, then releases channels in index |
// |            order, STAGGER_CYC cycles apart. Optional scan chain through  |
// |            the synchroniser flops: define CLUSTER_HDR_SEQ_SCAN_EN.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cluster_header_seq #(
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int STAGGER_CYC = 4
) (
    input  logic              gclk,
    input  logic              arst,
    input  logic              cluster_cken,
    input  logic [NUM_CH-1:0] grst_l_in,
`ifdef CLUSTER_HDR_SEQ_SCAN_EN
    input  logic              si,
    input  logic              se,
    output logic              so,
`endif
    output logic              rclk_en,
    output logic [NUM_CH-1:0] cluster_rst_l,
    output logic              rst_done
);

    localparam int c_nchain = NUM_CH + 1;
    localparam int c_nflop  = c_nchain * SYNC_STAGES;
    localparam int PW       = $clog2(NUM_CH + 1);
    localparam int CW       = $clog2(STAGGER_CYC + 1);
    localparam logic [PW-1:0] c_ptr_max  = PW'(NUM_CH);
    localparam logic [CW-1:0] c_cnt_last = CW'(STAGGER_CYC - 1);

    logic [c_nflop-1:0]  r_sync;
    logic [c_nflop-1:0]  w_sync_d;
    logic [c_nchain-1:0] w_chain_in;
    logic [NUM_CH-1:0]   w_s;
    logic                w_scan_en;
    logic                w_scan_in;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       w_ptr_next;
    logic [PW-1:0]       w_low_zero;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_next;
    logic [NUM_CH-1:0]   w_rst_l_next;

`ifdef CLUSTER_HDR_SEQ_SCAN_EN
    assign w_scan_en = se;
    assign w_scan_in = si;
    assign so        = r_sync[c_nflop-1];
`else
    assign w_scan_en = 1'b0;
    assign w_scan_in = 1'b0;
`endif

    // Chain 0 is the clock enable, chain c>0 carries grst_l_in[c-1].
    assign w_chain_in = {grst_l_in, cluster_cken};

    // All chains sit back to back in r_sync so scan only re-routes each stage 0.
    generate
        for (genvar f = 0; f < c_nflop; f++) begin : g_sync_d
            localparam int STG = f % SYNC_STAGES;
            localparam int CH  = f / SYNC_STAGES;
            if (f == 0) begin : g_head
                assign w_sync_d[f] = w_scan_en ? w_scan_in : w_chain_in[0];
            end else if (STG == 0) begin : g_stage0
                assign w_sync_d[f] = w_scan_en ? r_sync[f-1] : w_chain_in[CH];
            end else begin : g_inner
                assign w_sync_d[f] = r_sync[f-1];
            end
        end
        for (genvar i = 0; i < NUM_CH; i++) begin : g_tap
            assign w_s[i]          = r_sync[(i+2)*SYNC_STAGES-1];
            assign w_rst_l_next[i] = (w_ptr_next > PW'(i));
        end
    endgenerate

    assign rclk_en = r_sync[SYNC_STAGES-1];

    always_ff @(posedge gclk or posedge arst) begin
        if (arst) r_sync <= '0;
        else      r_sync <= w_sync_d;
    end

    always_comb begin
        w_low_zero = c_ptr_max;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!w_s[i]) w_low_zero = PW'(i);
        end
    end

    // A request dropping below ptr wins over everything and restarts the count.
    always_comb begin
        w_ptr_next = r_ptr;
        w_cnt_next = r_cnt;
        if (w_scan_en) begin
            w_ptr_next = r_ptr;
        end else if (w_low_zero < r_ptr) begin
            w_ptr_next = w_low_zero;
            w_cnt_next = '0;
        end else if ((r_ptr != c_ptr_max) && (w_low_zero == r_ptr)) begin
            w_cnt_next = '0;
        end else if ((r_ptr != c_ptr_max) && (r_cnt == c_cnt_last)) begin
            w_ptr_next = r_ptr + PW'(1);
            w_cnt_next = '0;
        end else if (r_ptr != c_ptr_max) begin
            w_cnt_next = r_cnt + CW'(1);
        end else begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge gclk or posedge arst) begin
        if (arst) begin
            r_ptr         <= '0;
            r_cnt         <= '0;
            cluster_rst_l <= '0;
            rst_done      <= 1'b0;
        end else begin
            r_ptr         <= w_ptr_next;
            r_cnt         <= w_cnt_next;
            cluster_rst_l <= w_rst_l_next;
            rst_done      <= (w_ptr_next == c_ptr_max);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cluster_header_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cluster_header_seq                                         |
// | Brief    : Scoreboard bench for cluster_header_seq (3 ch, 2 sync, 4 cyc) |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_cluster_header_seq;

    localparam int NUM_CH      = 3;
    localparam int SYNC_STAGES = 2;
    localparam int STAGGER_CYC = 4;

    logic              gclk = 1'b0;
    logic              arst = 1'b0;
    logic              cluster_cken = 1'b0;
    logic [NUM_CH-1:0] grst_l_in = '0;
    logic              rclk_en;
    logic [NUM_CH-1:0] cluster_rst_l;
    logic              rst_done;
    logic              so_mon;
`ifdef CLUSTER_HDR_SEQ_SCAN_EN
    logic si = 1'b0;
    logic se = 1'b0;
    logic so;
    assign so_mon = so;
`else
    assign so_mon = 1'b0;
`endif

    cluster_header_seq #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .STAGGER_CYC (STAGGER_CYC)
    ) dut (
        .gclk          (gclk),
        .arst          (arst),
        .cluster_cken  (cluster_cken),
        .grst_l_in     (grst_l_in),
`ifdef CLUSTER_HDR_SEQ_SCAN_EN
        .si            (si),
        .se            (se),
        .so            (so),
`endif
        .rclk_en       (rclk_en),
        .cluster_rst_l (cluster_rst_l),
        .rst_done      (rst_done)
    );

    always #5 gclk = ~gclk;

    int cyc = 0;
    always @(posedge gclk) cyc <= cyc + 1;

    typedef struct {
        string             name;
        int                edge_n;
        logic [NUM_CH-1:0] rst_l;
        logic              done;
        logic              rclk;
        logic              chk_rclk;
        logic              chk_so;
        logic              so_v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string nm, input int n, input logic [NUM_CH-1:0] r,
                        input logic d, input logic rc, input logic crc);
        exp_t e;
        e.name = nm; e.edge_n = n; e.rst_l = r; e.done = d;
        e.rclk = rc; e.chk_rclk = crc; e.chk_so = 1'b0; e.so_v = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_so(input string nm, input int n, input logic v);
        exp_t e;
        e.name = nm; e.edge_n = n; e.rst_l = '1; e.done = 1'b1;
        e.rclk = 1'b0; e.chk_rclk = 1'b0; e.chk_so = 1'b1; e.so_v = v;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge gclk);
    endtask

    // Monitor: state after edge N is sampled on the following falling edge.
    exp_t cur;
    logic ok;
    always @(negedge gclk) begin
        while (q.size() > 0 && q[0].edge_n <= cyc) begin
            cur   = q.pop_front();
            total = total + 1;
            if (cur.edge_n < cyc) begin
                bad = bad + 1;
                $display("FAIL %s: sampled at edge %0d, required edge %0d", cur.name, cyc, cur.edge_n);
            end else begin
                ok = 1'b1;
                if (cluster_rst_l !== cur.rst_l || rst_done !== cur.done) ok = 1'b0;
                if (cur.chk_rclk && rclk_en !== cur.rclk) ok = 1'b0;
                if (cur.chk_so && so_mon !== cur.so_v) ok = 1'b0;
                if (!ok) begin
                    bad = bad + 1;
                    $display("FAIL %s @edge %0d: got rst_l=%b done=%b rclk_en=%b so=%b, want rst_l=%b done=%b rclk_en=%b so=%b",
                             cur.name, cyc, cluster_rst_l, rst_done, rclk_en, so_mon,
                             cur.rst_l, cur.done, cur.rclk, cur.so_v);
                end
            end
        end
    end

    int e0, c, d, r, k, m, f, g, p;

    initial begin
        #1 arst = 1'b1;
        push("reset_e1", 1, 3'b000, 1'b0, 1'b0, 1'b1);
        push("reset_e2", 2, 3'b000, 1'b0, 1'b0, 1'b1);
        push("reset_e3", 3, 3'b000, 1'b0, 1'b0, 1'b1);
        wait_cyc(3);

        // Power-up release sequence
        e0 = cyc;
        arst = 1'b0; grst_l_in = '1; cluster_cken = 1'b1;
        push("t1_e1",    e0+1,  3'b000, 1'b0, 1'b0, 1'b1);
        push("t1_rclk",  e0+2,  3'b000, 1'b0, 1'b1, 1'b1);
        push("t1_pre0",  e0+5,  3'b000, 1'b0, 1'b1, 1'b1);
        push("t1_ch0",   e0+6,  3'b001, 1'b0, 1'b1, 1'b1);
        push("t1_pre1",  e0+9,  3'b001, 1'b0, 1'b1, 1'b1);
        push("t1_ch1",   e0+10, 3'b011, 1'b0, 1'b1, 1'b1);
        push("t1_pre2",  e0+13, 3'b011, 1'b0, 1'b1, 1'b1);
        push("t1_done",  e0+14, 3'b111, 1'b1, 1'b1, 1'b1);
        wait_cyc(e0+16);

        // Drop channel 1 for three cycles
        c = cyc;
        grst_l_in[1] = 1'b0;
        push("t2_still", c+2, 3'b111, 1'b1, 1'b1, 1'b1);
        push("t2_assert", c+3, 3'b001, 1'b0, 1'b1, 1'b1);
        wait_cyc(c+3);
        grst_l_in[1] = 1'b1;
        push("t2_pre1",  c+8,  3'b001, 1'b0, 1'b1, 1'b1);
        push("t2_ch1",   c+9,  3'b011, 1'b0, 1'b1, 1'b1);
        push("t2_pre2",  c+12, 3'b011, 1'b0, 1'b1, 1'b1);
        push("t2_done",  c+13, 3'b111, 1'b1, 1'b1, 1'b1);
        wait_cyc(c+15);

        // Hold channel 0 low: nothing may release until it rises
        d = cyc;
        grst_l_in[0] = 1'b0;
        push("t3_still",  d+2,  3'b111, 1'b1, 1'b1, 1'b1);
        push("t3_assert", d+3,  3'b000, 1'b0, 1'b1, 1'b1);
        push("t3_held",   d+12, 3'b000, 1'b0, 1'b1, 1'b1);
        wait_cyc(d+12);
        r = cyc;
        grst_l_in[0] = 1'b1;
        push("t3_pre0", r+5,  3'b000, 1'b0, 1'b1, 1'b1);
        push("t3_ch0",  r+6,  3'b001, 1'b0, 1'b1, 1'b1);
        push("t3_ch1",  r+10, 3'b011, 1'b0, 1'b1, 1'b1);
        push("t3_done", r+14, 3'b111, 1'b1, 1'b1, 1'b1);
        wait_cyc(r+16);

        // Clock-enable pulse of five cycles
        k = cyc;
        cluster_cken = 1'b0;
        push("t4_fall_lat", k+1, 3'b111, 1'b1, 1'b1, 1'b1);
        push("t4_fall",     k+2, 3'b111, 1'b1, 1'b0, 1'b1);
        wait_cyc(k+4);
        m = cyc;
        cluster_cken = 1'b1;
        push("t4_rise_lat", m+1, 3'b111, 1'b1, 1'b0, 1'b1);
        push("t4_rise",     m+2, 3'b111, 1'b1, 1'b1, 1'b1);
        push("t4_last_hi",  m+6, 3'b111, 1'b1, 1'b1, 1'b1);
        push("t4_low",      m+7, 3'b111, 1'b1, 1'b0, 1'b1);
        wait_cyc(m+5);
        cluster_cken = 1'b0;
        wait_cyc(m+8);
        cluster_cken = 1'b1;

        // Full restart, then an async reset pulse with ptr=1, cnt=2
        arst = 1'b1;
        push("t5_rst", m+9, 3'b000, 1'b0, 1'b0, 1'b1);
        wait_cyc(m+10);
        f = cyc;
        arst = 1'b0;
        push("t5_ch0",  f+6, 3'b001, 1'b0, 1'b1, 1'b1);
        push("t5_cnt1", f+7, 3'b001, 1'b0, 1'b1, 1'b1);
        push("t5_async", f+8, 3'b000, 1'b0, 1'b0, 1'b1);
        wait_cyc(f+7);
        @(posedge gclk);
        #2 arst = 1'b1;
        wait_cyc(f+9);
        g = cyc;
        arst = 1'b0;
        push("t5_r_e1",   g+1,  3'b000, 1'b0, 1'b0, 1'b1);
        push("t5_r_rclk", g+2,  3'b000, 1'b0, 1'b1, 1'b1);
        push("t5_r_pre0", g+5,  3'b000, 1'b0, 1'b1, 1'b1);
        push("t5_r_ch0",  g+6,  3'b001, 1'b0, 1'b1, 1'b1);
        push("t5_r_ch1",  g+10, 3'b011, 1'b0, 1'b1, 1'b1);
        push("t5_r_done", g+14, 3'b111, 1'b1, 1'b1, 1'b1);
        wait_cyc(g+16);

`ifdef CLUSTER_HDR_SEQ_SCAN_EN
        // Shift 1011 through the synchroniser chain
        p = cyc;
        se = 1'b1; si = 1'b1;
        push_so("t6_so_b0", p+8,  1'b1);
        push_so("t6_so_b1", p+9,  1'b0);
        push_so("t6_so_b2", p+10, 1'b1);
        push_so("t6_so_b3", p+11, 1'b1);
        push_so("t6_so_b4", p+12, 1'b0);
        wait_cyc(p+1); si = 1'b0;
        wait_cyc(p+2); si = 1'b1;
        wait_cyc(p+3); si = 1'b1;
        wait_cyc(p+4); si = 1'b0;
        wait_cyc(p+12);
        se = 1'b0;
`endif

        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge gclk);
        if (q.size() > 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
